// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
// The pc_call_stack header names the optional PC_STACK_WRAP_EN build macro.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF = 16;
    localparam int unsigned PC_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Fixed priority: load > call > ret > inc > hold
    function automatic pc_op_e pc_prio_op(
        input logic load,
        input logic call,
        input logic ret,
        input logic inc
    );
        pc_op_e op;
        op = PC_HOLD;
        if (load)      op = PC_LOAD;
        else if (call) op = PC_CALL;
        else if (ret)  op = PC_RET;
        else if (inc)  op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: storage, occupancy count and push/pop handling.
// PC_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module ras_lifo
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DEPTH = PC_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_sp,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [SPW-1:0]   r_sp;

    logic w_wr;
    logic w_sp_inc;
    logic w_pop;

    assign o_empty = (r_sp == '0);
    assign o_full  = (r_sp == SPW'(DEPTH));
    assign o_sp    = r_sp;
    assign o_dout  = r_mem[r_head - AW'(1)];

    // r_head is the next write slot; as a ring it lets a full push overwrite the oldest entry
`ifdef PC_STACK_WRAP_EN
    assign w_wr = i_push;
`else
    assign w_wr = i_push & ~o_full;
`endif
    assign w_sp_inc = i_push & ~o_full;
    assign w_pop    = i_pop & ~i_push & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_sp   <= '0;
        end else if (w_wr || w_sp_inc) begin
            if (w_wr) r_head <= r_head + AW'(1);
            if (w_sp_inc) r_sp <= r_sp + SPW'(1);
        end else if (w_pop) begin
            r_head <= r_head - AW'(1);
            r_sp   <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_head] <= i_din;
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump, call/return via a hardware RAS, and sticky stack error flags.
// Build macro PC_STACK_WRAP_EN selects overwrite-oldest behaviour on a call while full.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned     DEPTH     = PC_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic                   call,
    input  logic                   ret,
    input  logic                   inc,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_unf;

    pc_op_e           w_op;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_push;
    logic             w_pop;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_empty;
    logic             w_full;

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc_inc),
        .o_dout  (w_ras_top),
        .o_sp    (sp),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_op     = pc_prio_op(load, call, ret, inc);
    assign w_pc_inc = r_pc + WIDTH'(1);

    // Next PC, stack requests and error events for the winning operation
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        case (w_op)
            PC_LOAD: w_pc_nxt = in;
            PC_CALL: begin
                w_pc_nxt  = in;
                w_push    = 1'b1;
                w_set_ovf = w_full;
            end
            PC_RET: begin
                if (w_empty) begin
                    w_set_unf = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_ras_top;
                end
            end
            PC_INC:  w_pc_nxt = w_pc_inc;
            default: ;
        endcase
    end

    // A set in the same cycle as clr_err takes precedence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_VEC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
            r_unf <= w_set_unf | (r_unf & ~clr_err);
        end
    end

    assign out       = r_pc;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
